// File: rtl/uart_frame_decoder_if.sv
// Byte-in / frame-out signal bundle between the UART receiver side and the
// command-frame decoder. The decoder uses the slave modport.
interface uart_frame_decoder_if;
    logic [7:0]  rx_byte;
    logic        rx_ok;
    logic        frame_valid;
    logic [7:0]  cmd;
    logic [15:0] arg;
    logic        chk_err;
    logic        timeout_err;
    logic        busy;

    modport master (
        output rx_byte, rx_ok,
        input  frame_valid, cmd, arg, chk_err, timeout_err, busy
    );

    modport slave (
        input  rx_byte, rx_ok,
        output frame_valid, cmd, arg, chk_err, timeout_err, busy
    );
endinterface

// File: rtl/uart_frame_decoder.sv
// Assembles 5-byte command frames (HEADER, CMD, ARG_H, ARG_L, CHK) from UART bytes.
// Optional error counter port err_count is enabled with `define UART_FRAME_STATS_EN.
module uart_frame_decoder #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    uart_frame_decoder_if.slave  bus
`ifdef UART_FRAME_STATS_EN
    ,
    output logic [7:0]           err_count
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        S_CMD,
        S_ARGH,
        S_ARGL,
        S_CHK
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   stb_prev_q, stb_prev_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [7:0]             cmd_sh_q, cmd_sh_d;
    logic [7:0]             argh_sh_q, argh_sh_d;
    logic [7:0]             argl_sh_q, argl_sh_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [15:0]            arg_q, arg_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   chk_err_q, chk_err_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   busy_q, busy_d;

    logic                   byte_stb;
    logic [7:0]             chk_sum;

    // rx_ok may be asynchronous to CLK; only its synchronized copy is used.
    assign sync_d     = {sync_q[SYNC_STAGES-2:0], bus.rx_ok};
    assign stb_prev_d = sync_q[SYNC_STAGES-1];
    assign byte_stb   = sync_q[SYNC_STAGES-1] & ~stb_prev_q;

    // 8-bit result truncates the sum, giving the wrap-around checksum.
    assign chk_sum = cmd_sh_q + argh_sh_q + argl_sh_q;

    // NOTE: every signal gets its default before the case below, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        cmd_sh_d      = cmd_sh_q;
        argh_sh_d     = argh_sh_q;
        argl_sh_d     = argl_sh_q;
        cmd_d         = cmd_q;
        arg_d         = arg_q;
        frame_valid_d = 1'b0;
        chk_err_d     = 1'b0;
        timeout_err_d = 1'b0;

        if (byte_stb) begin
            // A byte arriving in the expiry cycle is processed; no timeout.
            tmo_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (bus.rx_byte == HEADER) state_d = S_CMD;
                end
                S_CMD: begin
                    cmd_sh_d = bus.rx_byte;
                    state_d  = S_ARGH;
                end
                S_ARGH: begin
                    argh_sh_d = bus.rx_byte;
                    state_d   = S_ARGL;
                end
                S_ARGL: begin
                    argl_sh_d = bus.rx_byte;
                    state_d   = S_CHK;
                end
                S_CHK: begin
                    if (bus.rx_byte == chk_sum) begin
                        cmd_d         = cmd_sh_q;
                        arg_d         = {argh_sh_q, argl_sh_q};
                        frame_valid_d = 1'b1;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            state_d       = IDLE;
            timeout_err_d = 1'b1;
            tmo_d         = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            stb_prev_q    <= 1'b0;
            tmo_q         <= '0;
            cmd_sh_q      <= '0;
            argh_sh_q     <= '0;
            argl_sh_q     <= '0;
            cmd_q         <= '0;
            arg_q         <= '0;
            frame_valid_q <= 1'b0;
            chk_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            stb_prev_q    <= stb_prev_d;
            tmo_q         <= tmo_d;
            cmd_sh_q      <= cmd_sh_d;
            argh_sh_q     <= argh_sh_d;
            argl_sh_q     <= argl_sh_d;
            cmd_q         <= cmd_d;
            arg_q         <= arg_d;
            frame_valid_q <= frame_valid_d;
            chk_err_q     <= chk_err_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.frame_valid = frame_valid_q;
    assign bus.cmd         = cmd_q;
    assign bus.arg         = arg_q;
    assign bus.chk_err     = chk_err_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.busy        = busy_q;

`ifdef UART_FRAME_STATS_EN
    logic [7:0] err_count_q, err_count_d;

    // Counts dropped frames; holds at 8'hFF instead of wrapping.
    always_comb begin
        err_count_d = err_count_q;
        if ((chk_err_d || timeout_err_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) err_count_q <= '0;
        else        err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder: a byte-level frame model pushes the
// expected event per frame, a monitor pops and compares on each output pulse.
module tb_uart_frame_decoder;

    localparam int         T_CYC = 200;
    localparam logic [7:0] HDR   = 8'hA5;

    typedef enum logic [1:0] {EV_GOOD, EV_CHK, EV_TMO, EV_NONE} ev_kind_e;
    typedef struct packed {
        ev_kind_e    kind;
        logic [7:0]  cmd;
        logic [15:0] arg;
    } exp_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    uart_frame_decoder_if bus ();
`ifdef UART_FRAME_STATS_EN
    logic [7:0] err_count;
`endif

    uart_frame_decoder #(
        .HEADER      (HDR),
        .TIMEOUT_CYC (T_CYC),
        .SYNC_STAGES (2)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
`ifdef UART_FRAME_STATS_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 CLK = ~CLK;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Reference frame model
    int          m_idx = 0;
    logic [7:0]  m_b [3];
    logic [7:0]  m_cmd = 8'h00;
    logic [15:0] m_arg = 16'h0000;
    int          m_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_ev(input ev_kind_e k);
        exp_t e;
        e.kind = k;
        e.cmd  = m_cmd;
        e.arg  = m_arg;
        exp_q.push_back(e);
        if (k != EV_GOOD && m_err < 255) m_err++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] s;
        if (m_idx == 0) begin
            if (b == HDR) m_idx = 1;
        end else if (m_idx < 4) begin
            m_b[m_idx-1] = b;
            m_idx++;
        end else begin
            s = 8'(m_b[0] + m_b[1] + m_b[2]);
            if (b == s) begin
                m_cmd = m_b[0];
                m_arg = {m_b[1], m_b[2]};
                push_ev(EV_GOOD);
            end else begin
                push_ev(EV_CHK);
            end
            m_idx = 0;
        end
    endtask

    // One rx_ok pulse per byte; returns 9 falling edges after raising rx_ok.
    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        @(negedge CLK);
        bus.rx_byte = b;
        bus.rx_ok   = 1'b1;
        repeat (5) @(negedge CLK);
        bus.rx_ok = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(b4);
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (exp_q.size() != 0 && w < 3 * T_CYC) begin
            @(negedge CLK);
            w++;
        end
        repeat (4) @(negedge CLK);
        check(tag, exp_q.size(), 0);
    endtask

    // Monitor: every output pulse must match the next expected event.
    logic     prev_pulse = 1'b0;
    logic [2:0] pulses;
    ev_kind_e got_kind;
    exp_t     mon_e;

    always @(negedge CLK) begin
        if (RST_N) begin
            pulses = {bus.frame_valid, bus.chk_err, bus.timeout_err};
            if (pulses != 3'b000) begin
                check("pulse_onehot", $countones(pulses), 1);
                check("pulse_gap", prev_pulse, 1'b0);
                got_kind = bus.frame_valid ? EV_GOOD : (bus.chk_err ? EV_CHK : EV_TMO);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", pulses, 3'b000);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ev_kind", got_kind, mon_e.kind);
                    check("ev_cmd", bus.cmd, mon_e.cmd);
                    check("ev_arg", bus.arg, mon_e.arg);
                end
            end
            prev_pulse = |pulses;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.rx_byte = 8'h00;
        bus.rx_ok   = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_cmd", bus.cmd, 8'h00);
        check("rst_arg", bus.arg, 16'h0000);
        check("rst_pulses", {bus.frame_valid, bus.chk_err, bus.timeout_err}, 3'b000);
`ifdef UART_FRAME_STATS_EN
        check("rst_err_count", err_count, 8'h00);
`endif
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);

        // 1: good frame
        send_frame(8'hA5, 8'h10, 8'h12, 8'h34, 8'h56);
        drain("drain_good");
        check("t1_cmd", bus.cmd, 8'h10);
        check("t1_arg", bus.arg, 16'h1234);

        // 2: bad checksum keeps previous cmd/arg
        send_frame(8'hA5, 8'h10, 8'h12, 8'h34, 8'h57);
        drain("drain_chk");
        check("t2_busy", bus.busy, 1'b0);
        check("t2_cmd", bus.cmd, 8'h10);

        // 3: leading garbage ignored
        send_byte(8'h00);
        send_byte(8'hFF);
        check("t3_busy_idle", bus.busy, 1'b0);
        send_frame(8'hA5, 8'h01, 8'h00, 8'h02, 8'h03);
        drain("drain_garbage");
        check("t3_arg", bus.arg, 16'h0002);

        // 4: inter-byte timeout, then normal frame
        send_byte(8'hA5);
        send_byte(8'h10);
        check("t4_busy_mid", bus.busy, 1'b1);
        m_idx = 0;
        push_ev(EV_TMO);
        w = 0;
        while (!bus.timeout_err && w < 2 * T_CYC) begin
            @(negedge CLK);
            w++;
        end
        check("t4_tmo_latency", w, T_CYC - 6);
        @(negedge CLK);
        check("t4_busy_after", bus.busy, 1'b0);
        drain("drain_tmo");
        send_frame(8'hA5, 8'h20, 8'h00, 8'h05, 8'h25);
        drain("drain_after_tmo");
`ifdef UART_FRAME_STATS_EN
        check("err_count_two", err_count, 8'(m_err));
`endif

        // 5: checksum wrap-around, header value used as data
        send_frame(8'hA5, 8'hFF, 8'h01, 8'h00, 8'h00);
        drain("drain_wrap");
        check("t5_cmd", bus.cmd, 8'hFF);
        send_frame(8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h4A);
        drain("drain_hdr_data");
        check("t5_arg_hdr", bus.arg, 16'hA500);

        // 6: reset mid-frame
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h12);
        RST_N = 1'b0;
        #1;
        check("t6_busy", bus.busy, 1'b0);
        check("t6_cmd", bus.cmd, 8'h00);
        check("t6_arg", bus.arg, 16'h0000);
        m_idx = 0;
        m_cmd = 8'h00;
        m_arg = 16'h0000;
        m_err = 0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        send_frame(8'hA5, 8'h03, 8'h00, 8'h01, 8'h04);
        drain("drain_after_rst");
        check("t6_cmd_after", bus.cmd, 8'h03);

`ifdef UART_FRAME_STATS_EN
        for (int i = 0; i < 300; i++) begin
            send_frame(8'hA5, 8'h01, 8'h02, 8'h03, 8'h00);
            if (i == 2) begin
                drain("drain_stats3");
                check("err_count_3", err_count, 8'd3);
            end
        end
        drain("drain_stats");
        check("err_count_sat", err_count, 8'hFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
